// File: rtl/cpu_pkg.sv
// Shared CPU datapath types and constants used by the register file and the ALU.
package cpu_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned REG_ADDR_W = 3;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     word_t;

    localparam reg_addr_t REG_ZERO = REG_ADDR_W'(0);

endpackage : cpu_pkg

// File: rtl/alu_flags_reg.sv
// Two-bit status register capturing ALU carry-out and zero for later conditional branches.
module alu_flags_reg (
    input  logic clk,
    input  logic reset,
    input  logic flag_we,
    input  logic alu_cout,
    input  logic alu_zero,
    output logic flag_c,
    output logic flag_z
);

    logic [1:0] flags_q;
    logic [1:0] flags_d;

    always_comb begin
        flags_d = flags_q;
        if (flag_we) begin
            flags_d = {alu_cout, alu_zero};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 2'b00;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flag_c = flags_q[1];
    assign flag_z = flags_q[0];

endmodule : alu_flags_reg

// File: rtl/regfile_16bit.sv
// Eight-entry register file with hardwired r0 and ALU status flags.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module regfile_16bit #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [cpu_pkg::REG_ADDR_W-1:0] ra1,
    input  logic [cpu_pkg::REG_ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0]              rd1,
    output logic [DATA_W-1:0]              rd2,
    input  logic                           we,
    input  logic [cpu_pkg::REG_ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0]              wd,
    input  logic                           flag_we,
    input  logic                           alu_cout,
    input  logic                           alu_zero,
    output logic                           flag_c,
    output logic                           flag_z
);

    import cpu_pkg::*;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic              wr_en_c;

    assign wr_en_c = we && (wa != REG_ZERO);

    always_comb begin
        regs_d = regs_q;
        if (wr_en_c) begin
            regs_d[wa] = wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // r0 is masked on read so it reads zero regardless of array contents.
    always_comb begin
        rd1 = (ra1 == REG_ZERO) ? '0 : regs_q[ra1];
        rd2 = (ra2 == REG_ZERO) ? '0 : regs_q[ra2];
`ifdef REGFILE_BYPASS_EN
        if (wr_en_c && !reset && (wa == ra1)) begin
            rd1 = wd;
        end
        if (wr_en_c && !reset && (wa == ra2)) begin
            rd2 = wd;
        end
`endif
    end

    alu_flags_reg u_flags (
        .clk      (clk),
        .reset    (reset),
        .flag_we  (flag_we),
        .alu_cout (alu_cout),
        .alu_zero (alu_zero),
        .flag_c   (flag_c),
        .flag_z   (flag_z)
    );

endmodule : regfile_16bit
